// File: rtl/text_pkg.sv
// Shared geometry, control codes and controller states for the text window.
package text_pkg;

  localparam int TXT_COLS = 32;
  localparam int TXT_ROWS = 4;
  localparam int TXT_X0   = 192;
  localparam int TXT_Y0   = 208;
  localparam int CHAR_W   = 8;
  localparam int CHAR_H   = 16;

  localparam logic [7:0] CC_BS    = 8'h08;
  localparam logic [7:0] CC_CR    = 8'h0D;
  localparam logic [7:0] CC_FF    = 8'h0C;
  localparam logic [7:0] CC_SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    SCROLL = 2'd2
  } state_e;

  // ASCII 0x20..0x7E plus the whole Thai half 0x80..0xFF.
  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c != 8'h7F);
  endfunction

endpackage

// File: rtl/text_buffer_ram.sv
// 128x8 character store: one write port, a registered display read port and
// a combinational read port used while scrolling.
module text_buffer_ram (
  input  logic       clk_i,
  input  logic       wr_en_i,
  input  logic [6:0] wr_addr_i,
  input  logic [7:0] wr_data_i,
  input  logic [6:0] rd_addr_i,
  output logic [7:0] rd_data_o,
  input  logic [6:0] sc_addr_i,
  output logic [7:0] sc_data_o
);

  logic [7:0] mem_q [128];
  logic [7:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Read-before-write: a same-edge write is not visible on the display port.
  always_ff @(posedge clk_i) begin
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;
  assign sc_data_o = mem_q[sc_addr_i];

endmodule

// File: rtl/text_buffer_ctrl.sv
// Text window controller: accepts bytes, edits the 32x4 buffer, and serves
// the renderer one character code and cursor flag per pixel.
//
//   state  | meaning
//   IDLE   | ready for a byte; decodes printable / CR / BS / FF
//   CLEAR  | writes space to cells 0..127, one per cycle
//   SCROLL | copies rows 1..3 up to rows 0..2, then blanks row 3
module text_buffer_ctrl
  import text_pkg::*;
#(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  output logic       rx_ready_o,
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  output logic [7:0] ascii_code_o,
  output logic       cursor_on_o,
  output logic       busy_o
);

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [9:0] X_LO = 10'(TXT_X0);
  localparam logic [9:0] X_HI = 10'(TXT_X0 + TXT_COLS * CHAR_W);
  localparam logic [9:0] Y_LO = 10'(TXT_Y0);
  localparam logic [9:0] Y_HI = 10'(TXT_Y0 + TXT_ROWS * CHAR_H);

  state_e         state_q, state_d;
  logic [6:0]     idx_q, idx_d;
  logic [1:0]     row_q, row_d;
  logic [4:0]     col_q, col_d;
  logic [BW-1:0]  blink_cnt_q;
  logic           blink_ph_q;
  logic           in_win_q;
  logic           cursor_on_q;

  logic           wr_en;
  logic [6:0]     wr_addr;
  logic [7:0]     wr_data;
  logic [7:0]     rd_data;
  logic [7:0]     sc_data;

  logic [9:0]     xo, yo;
  logic [4:0]     pix_col;
  logic [1:0]     pix_row;
  logic           in_win, cur_hit, blink_last;

  assign xo      = x_i - X_LO;
  assign yo      = y_i - Y_LO;
  assign pix_col = xo[7:3];
  assign pix_row = yo[5:4];
  assign in_win  = (x_i >= X_LO) && (x_i < X_HI) && (y_i >= Y_LO) && (y_i < Y_HI);
  assign cur_hit = in_win && (pix_row == row_q) && (pix_col == col_q);
  assign blink_last = (blink_cnt_q == BW'(BLINK_DIV - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= CLEAR;
      idx_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      in_win_q    <= 1'b0;
      cursor_on_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      row_q       <= row_d;
      col_q       <= col_d;
      blink_cnt_q <= blink_last ? '0 : blink_cnt_q + 1'b1;
      blink_ph_q  <= blink_ph_q ^ blink_last;
      in_win_q    <= in_win;
      cursor_on_q <= cur_hit && blink_ph_q;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    row_d   = row_q;
    col_d   = col_q;
    wr_en   = 1'b0;
    wr_addr = {row_q, col_q};
    wr_data = CC_SPACE;
    case (state_q)
      IDLE: begin
        if (rx_valid_i) begin
          if (is_printable(rx_data_i) || rx_data_i == CC_CR) begin
            if (rx_data_i != CC_CR) begin
              wr_en   = 1'b1;
              wr_data = rx_data_i;
            end
            if (rx_data_i == CC_CR || col_q == 5'd31) begin
              col_d = '0;
              if (row_q == 2'd3) begin
                state_d = SCROLL;
                idx_d   = '0;
              end else begin
                row_d = row_q + 2'd1;
              end
            end else begin
              col_d = col_q + 5'd1;
            end
          end else if (rx_data_i == CC_BS) begin
            if (row_q != 2'd0 || col_q != 5'd0) begin
              if (col_q == 5'd0) begin
                row_d = row_q - 2'd1;
                col_d = 5'd31;
              end else begin
                col_d = col_q - 5'd1;
              end
              wr_en   = 1'b1;
              wr_addr = {row_d, col_d};
            end
          end else if (rx_data_i == CC_FF) begin
            state_d = CLEAR;
            idx_d   = '0;
            row_d   = '0;
            col_d   = '0;
          end
        end
      end
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = idx_q;
        idx_d   = idx_q + 7'd1;
        if (idx_q == 7'd127) state_d = IDLE;
      end
      SCROLL: begin
        wr_en   = 1'b1;
        wr_addr = idx_q;
        wr_data = (idx_q < 7'd96) ? sc_data : CC_SPACE;
        idx_d   = idx_q + 7'd1;
        if (idx_q == 7'd127) begin
          state_d = IDLE;
          row_d   = 2'd3;
          col_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  text_buffer_ram u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i ({pix_row, pix_col}),
    .rd_data_o (rd_data),
    .sc_addr_i (idx_q + 7'd32),
    .sc_data_o (sc_data)
  );

  assign rx_ready_o   = (state_q == IDLE);
  assign busy_o       = ~rx_ready_o;
  assign ascii_code_o = in_win_q ? rd_data : CC_SPACE;
  assign cursor_on_o  = cursor_on_q;

endmodule
